booth_mul_seq: RTL and testbench

//  Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product, one Booth step/cycle.

---
 rtl/booth_mul_seq_if.sv | 23 ++
 rtl/booth_mul_seq.sv | 133 +++++++++++++
 tb/tb_booth_mul_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_seq_if.sv
// Start/done handshake and operand/result bus for the sequential Booth multiplier.
// master = control unit side, slave = multiplier side.
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             iStart;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oHi;
    logic [WIDTH-1:0] oLo;

    modport master (
        output iStart, iA, iB,
        input  oBusy, oDone, oHi, oLo
    );

    modport slave (
        input  iStart, iA, iB,
        output oBusy, oDone, oHi, oLo
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH, one step per cycle.
// Optional MUL_EARLY_EXIT_EN: zero operands skip RUN and complete one cycle after acceptance.
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic            iClk,
    input  logic            iRst_n,
    booth_mul_seq_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 4 || WIDTH > 64 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("booth_mul_seq: WIDTH must be even and within 4..64");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    count;
    logic [WIDTH:0]   m;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic             accept;
    logic             last_step;
    logic             zero_op;
    logic             busy;
    logic             done;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_sh;
    logic [WIDTH-1:0] q_sh;

`ifdef MUL_EARLY_EXIT_EN
    assign zero_op = (bus.iA == '0) || (bus.iB == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_step = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    accept    = 1'b1;
                    state_nxt = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ACC carries one guard bit so that subtracting M = -2^(WIDTH-1) cannot wrap.
    always_comb begin
        case ({q[0], qm1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_sh = {sum[WIDTH], sum[WIDTH:1]};
        q_sh   = {sum[0], q[WIDTH-1:1]};
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept) begin
            m     <= {bus.iA[WIDTH-1], bus.iA};
            acc   <= '0;
            q     <= bus.iB;
            qm1   <= 1'b0;
            count <= '0;
            if (zero_op) begin
                hi <= '0;
                lo <= '0;
            end
        end else if (state == RUN) begin
            acc   <= acc_sh;
            q     <= q_sh;
            qm1   <= q[0];
            count <= count + CW'(1);
            // Result registers only move on the final step, so partial products never show.
            if (last_step) begin
                hi <= acc_sh[WIDTH-1:0];
                lo <= q_sh;
            end
        end
    end

    assign bus.oBusy = busy;
    assign bus.oDone = done;
    assign bus.oHi   = hi;
    assign bus.oLo   = lo;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (WIDTH=32): random and directed operands vs. a plain
// signed-multiply reference, latency, handshake, mid-run reset and back-to-back behaviour.
module tb_booth_mul_seq;

    localparam int W = 32;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic iClk   = 1'b0;
    logic iRst_n = 1'b0;

    booth_mul_seq_if #(.WIDTH(W)) bus ();

    booth_mul_seq #(.WIDTH(W)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    always #5 iClk = ~iClk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
    endfunction

    function automatic int exp_edge(input logic [31:0] a, input logic [31:0] b);
        return (EE && (a == 0 || b == 0)) ? 0 : W;
    endfunction

    function automatic logic [31:0] nz_rand();
        logic [31:0] v;
        v = $urandom;
        if (v == 0) v = 32'd1;
        return v;
    endfunction

    // One operation: accept, wait for oDone, check latency/result/handshake; ends in IDLE at a negedge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag,
                          output logic [63:0] prod);
        int e;
        @(negedge iClk);
        bus.iStart = 1'b1; bus.iA = a; bus.iB = b;
        @(posedge iClk);
        @(negedge iClk);
        bus.iStart = 1'b0; bus.iA = $urandom; bus.iB = $urandom;
        e = 0;
        while (bus.oDone !== 1'b1 && e < 4 * W) begin
            checks++;
            if (bus.oBusy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy_run edge=%0d got=%b want=1", tag, e, bus.oBusy);
            end
            @(posedge iClk);
            @(negedge iClk);
            e++;
        end
        checks++;
        if (e != exp_edge(a, b)) begin
            failures++;
            $display("FAIL %s latency got_edge=%0d want_edge=%0d", tag, e, exp_edge(a, b));
        end
        prod = {bus.oHi, bus.oLo};
        checks++;
        if (prod !== ref_mul(a, b)) begin
            failures++;
            $display("FAIL %s product a=%h b=%h got=%h want=%h", tag, a, b, prod, ref_mul(a, b));
        end
        checks++;
        if (bus.oBusy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_done got=%b want=1", tag, bus.oBusy);
        end
        @(negedge iClk);
        checks++;
        if ({bus.oDone, bus.oBusy} !== 2'b00 || {bus.oHi, bus.oLo} !== ref_mul(a, b)) begin
            failures++;
            $display("FAIL %s after_done done/busy=%b%b prod=%h want 00 prod=%h",
                     tag, bus.oDone, bus.oBusy, {bus.oHi, bus.oLo}, ref_mul(a, b));
        end
    endtask

    task automatic test_reset();
        bus.iStart = 1'b1; bus.iA = 32'd5; bus.iB = 32'd6;
        iRst_n = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        checks++;
        if ({bus.oBusy, bus.oDone} !== 2'b00 || bus.oHi !== 32'h0 || bus.oLo !== 32'h0) begin
            failures++;
            $display("FAIL reset busy=%b done=%b hi=%h lo=%h want all 0",
                     bus.oBusy, bus.oDone, bus.oHi, bus.oLo);
        end
        bus.iStart = 1'b0;
        iRst_n = 1'b1;
        repeat (2) @(negedge iClk);
        checks++;
        if (bus.oBusy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b want=0", bus.oBusy);
        end
    endtask

    task automatic test_directed();
        logic [63:0] p;
        run_op(32'd7, 32'hFFFF_FFFD, "7x-3", p);
        checks++;
        if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            failures++;
            $display("FAIL 7x-3_const got=%h want=ffffffffffffffeb", p);
        end
        run_op(32'h8000_0000, 32'h8000_0000, "min_x_min", p);
        checks++;
        if (p !== 64'h4000_0000_0000_0000) begin
            failures++;
            $display("FAIL min_x_min_const got=%h want=4000000000000000", p);
        end
        run_op(32'h7FFF_FFFF, 32'h8000_0000, "max_x_min", p);
        checks++;
        if (p !== 64'hC000_0000_8000_0000) begin
            failures++;
            $display("FAIL max_x_min_const got=%h want=c000000080000000", p);
        end
        repeat (5) @(negedge iClk);
        checks++;
        if ({bus.oHi, bus.oLo} !== 64'hC000_0000_8000_0000) begin
            failures++;
            $display("FAIL hold_idle got=%h want=c000000080000000", {bus.oHi, bus.oLo});
        end
    endtask

    task automatic test_zero();
        logic [63:0] p;
        run_op(32'd0, 32'h1234, "zero_a", p);
        run_op(32'd123, 32'd45, "nonzero_between", p);
        run_op(32'hDEAD_BEEF, 32'd0, "zero_b", p);
    endtask

    task automatic test_random();
        logic [63:0] p;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h0;
                3: b = 32'h7FFF_FFFF;
                default: ;
            endcase
            run_op(a, b, "random", p);
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] a, b;
        logic [63:0] p;
        int e;
        a = nz_rand(); b = nz_rand();
        @(negedge iClk);
        bus.iStart = 1'b1; bus.iA = a; bus.iB = b;
        @(posedge iClk);
        @(negedge iClk);
        bus.iStart = 1'b0;
        repeat (9) @(posedge iClk);
        @(negedge iClk);
        bus.iStart = 1'b1; bus.iA = nz_rand(); bus.iB = nz_rand();
        @(posedge iClk);
        @(negedge iClk);
        bus.iStart = 1'b0;
        e = 10;
        while (bus.oDone !== 1'b1 && e < 4 * W) begin
            @(posedge iClk);
            @(negedge iClk);
            e++;
        end
        checks++;
        if (e != W) begin
            failures++;
            $display("FAIL ignore_start latency got_edge=%0d want_edge=%0d", e, W);
        end
        p = {bus.oHi, bus.oLo};
        checks++;
        if (p !== ref_mul(a, b)) begin
            failures++;
            $display("FAIL ignore_start product got=%h want=%h", p, ref_mul(a, b));
        end
        repeat (3) @(negedge iClk);
        checks++;
        if (bus.oBusy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start queued busy=%b want=0", bus.oBusy);
        end
    endtask

    task automatic test_reset_midrun();
        logic [63:0] p;
        int pulses;
        run_op(32'd1000, 32'd77, "pre_reset", p);
        @(negedge iClk);
        bus.iStart = 1'b1; bus.iA = nz_rand(); bus.iB = nz_rand();
        @(posedge iClk);
        @(negedge iClk);
        bus.iStart = 1'b0;
        repeat (15) @(posedge iClk);
        #1 iRst_n = 1'b0;
        #1;
        checks++;
        if ({bus.oBusy, bus.oDone} !== 2'b00 || {bus.oHi, bus.oLo} !== 64'h0) begin
            failures++;
            $display("FAIL reset_midrun busy=%b done=%b prod=%h want all 0",
                     bus.oBusy, bus.oDone, {bus.oHi, bus.oLo});
        end
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge iClk);
            if (bus.oDone === 1'b1 || bus.oBusy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_midrun activity got=%0d want=0", pulses);
        end
        run_op($urandom, $urandom, "post_reset", p);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        int gap;
        a = nz_rand(); b = nz_rand();
        @(negedge iClk);
        bus.iStart = 1'b1; bus.iA = a; bus.iB = b;
        for (int op = 0; op < 4; op++) begin
            gap = 0;
            do begin
                @(posedge iClk);
                @(negedge iClk);
                gap++;
            end while (bus.oDone !== 1'b1 && gap < 4 * W);
            checks++;
            if (gap != ((op == 0) ? W + 1 : W + 2)) begin
                failures++;
                $display("FAIL b2b gap op=%0d got=%0d want=%0d", op, gap,
                         (op == 0) ? W + 1 : W + 2);
            end
            checks++;
            if ({bus.oHi, bus.oLo} !== ref_mul(a, b)) begin
                failures++;
                $display("FAIL b2b product op=%0d got=%h want=%h", op, {bus.oHi, bus.oLo},
                         ref_mul(a, b));
            end
            if (op == 3) begin
                bus.iStart = 1'b0;
            end else begin
                a = nz_rand(); b = nz_rand();
                bus.iA = a; bus.iB = b;
            end
        end
        repeat (3) @(negedge iClk);
        checks++;
        if (bus.oBusy !== 1'b0) begin
            failures++;
            $display("FAIL b2b drain busy=%b want=0", bus.oBusy);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iStart = 1'b0;
        bus.iA = '0;
        bus.iB = '0;
        test_reset();
        test_directed();
        test_zero();
        test_random();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
